// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes, fetch waits and HALT.
// Control outputs are combinational from state and inputs; state and counters are registered.
module pipeline_hazard_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  id_rs1,
    input  logic [2:0]  id_rs2,
    input  logic        id_uses_rs2,
    input  logic        ex_mem_read,
    input  logic [2:0]  ex_rd,
    input  logic        id_branch_taken,
    input  logic        id_halt,
    input  logic        imem_ready,
    output logic        pc_ld,
    output logic        ifid_ld,
    output logic        if_flush,
    output logic        idex_bubble,
    output logic        halted,
    output logic        fetch_timeout,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_count
);

    typedef enum logic [1:0] {
        S_RUN        = 2'd0,
        S_FETCH_WAIT = 2'd1,
        S_HALTED     = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] stall_q, stall_d;
    logic [15:0] flush_q, flush_d;
    logic [7:0]  wait_q, wait_d;
    logic        timeout_q, timeout_d;
    logic        load_use;
    logic        flush_evt;

    // Register 0 is hardwired, so a load targeting it never creates a dependency.
    assign load_use = ex_mem_read && (ex_rd != 3'd0) &&
                      ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

    always_comb begin
        state_d     = state_q;
        pc_ld       = 1'b0;
        ifid_ld     = 1'b0;
        if_flush    = 1'b0;
        idex_bubble = 1'b0;
        flush_evt   = 1'b0;
        if (reset) begin
            if_flush    = 1'b1;
            idex_bubble = 1'b1;
            state_d     = S_RUN;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (load_use) begin
                        idex_bubble = 1'b1;
                    end else if (id_halt) begin
                        idex_bubble = 1'b1;
                        state_d     = S_HALTED;
                    end else if (id_branch_taken) begin
                        pc_ld     = 1'b1;
                        ifid_ld   = 1'b1;
                        if_flush  = 1'b1;
                        flush_evt = 1'b1;
                        state_d   = imem_ready ? S_RUN : S_FETCH_WAIT;
                    end else if (!imem_ready) begin
                        ifid_ld  = 1'b1;
                        if_flush = 1'b1;
                        state_d  = S_FETCH_WAIT;
                    end else begin
                        pc_ld   = 1'b1;
                        ifid_ld = 1'b1;
                    end
                end
                S_FETCH_WAIT: begin
                    ifid_ld = 1'b1;
                    if (imem_ready) begin
                        pc_ld   = 1'b1;
                        state_d = S_RUN;
                    end else begin
                        if_flush = 1'b1;
                    end
                end
                S_HALTED: begin
                    idex_bubble = 1'b1;
                end
                default: begin
                    idex_bubble = 1'b1;
                    state_d     = S_RUN;
                end
            endcase
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (!pc_ld && (state_q != S_HALTED) && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
        flush_d = flush_q;
        if (flush_evt && (flush_q != 16'hFFFF)) begin
            flush_d = flush_q + 16'd1;
        end
        // The count also advances on the cycle that leaves FETCH_WAIT; it saturates so the flag stays meaningful.
        wait_d = wait_q;
        if (state_q == S_FETCH_WAIT) begin
            wait_d = (wait_q == 8'hFF) ? 8'hFF : wait_q + 8'd1;
        end else if (state_d == S_FETCH_WAIT) begin
            wait_d = 8'd0;
        end
        timeout_d = timeout_q | (wait_q == 8'hFF);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_RUN;
            stall_q   <= 16'd0;
            flush_q   <= 16'd0;
            wait_q    <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            stall_q   <= stall_d;
            flush_q   <= flush_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    assign halted        = (state_q == S_HALTED);
    assign fetch_timeout = timeout_q | (wait_q == 8'hFF);
    assign stall_cycles  = stall_q;
    assign flush_count   = flush_q;

endmodule
